// File: rtl/alu_rs.sv
// Reservation station in front of the ALU: buffers dispatched ops, captures
// operands from the ALU/LSB result buses and issues the lowest ready entry.
module alu_rs #(
    parameter int unsigned RS_SIZE    = 8,
    parameter int unsigned RS_BIT     = 3,
    parameter int unsigned REG_BIT    = 5,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  clr,
    input  logic                  disp_en,
    input  logic [2:0]            disp_tp,
    input  logic [5:0]            disp_op,
    input  logic [DATA_WIDTH-1:0] disp_vj,
    input  logic [REG_BIT-1:0]    disp_qj,
    input  logic                  disp_rj,
    input  logic [DATA_WIDTH-1:0] disp_vk,
    input  logic [REG_BIT-1:0]    disp_qk,
    input  logic                  disp_rk,
    input  logic [REG_BIT-1:0]    disp_rd,
    output logic                  full,
    input  logic                  cdb_alu_en,
    input  logic [REG_BIT-1:0]    cdb_alu_rd,
    input  logic [DATA_WIDTH-1:0] cdb_alu_data,
    input  logic                  cdb_lsb_en,
    input  logic [REG_BIT-1:0]    cdb_lsb_rd,
    input  logic [DATA_WIDTH-1:0] cdb_lsb_data,
    input  logic                  alu_rdy,
    output logic                  alu_en,
    output logic [2:0]            alu_tp,
    output logic [5:0]            alu_op,
    output logic [DATA_WIDTH-1:0] alu_lhs,
    output logic [DATA_WIDTH-1:0] alu_rhs,
    output logic [REG_BIT-1:0]    alu_rd
);

    logic [RS_SIZE-1:0]    busy;
    logic [RS_SIZE-1:0]    ent_rj;
    logic [RS_SIZE-1:0]    ent_rk;
    logic [2:0]            ent_tp [RS_SIZE];
    logic [5:0]            ent_op [RS_SIZE];
    logic [DATA_WIDTH-1:0] ent_vj [RS_SIZE];
    logic [DATA_WIDTH-1:0] ent_vk [RS_SIZE];
    logic [REG_BIT-1:0]    ent_qj [RS_SIZE];
    logic [REG_BIT-1:0]    ent_qk [RS_SIZE];
    logic [REG_BIT-1:0]    ent_rd [RS_SIZE];

    logic [RS_BIT-1:0]     free_idx;
    logic [RS_BIT-1:0]     iss_idx;
    logic                  iss_found;
    logic                  iss_fire;
    logic                  disp_fire;
    logic                  dj_rdy;
    logic                  dk_rdy;
    logic [DATA_WIDTH-1:0] dj_val;
    logic [DATA_WIDTH-1:0] dk_val;

    assign full      = &busy;
    assign iss_fire  = alu_rdy && iss_found;
    assign disp_fire = disp_en && !full;

    // Lowest free slot for allocation and lowest fully-ready slot for issue.
    always_comb begin
        logic free_found;
        free_found = 1'b0;
        free_idx   = '0;
        iss_found  = 1'b0;
        iss_idx    = '0;
        for (int i = 0; i < int'(RS_SIZE); i++) begin
            if (!busy[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = RS_BIT'(i);
            end
            if (busy[i] && ent_rj[i] && ent_rk[i] && !iss_found) begin
                iss_found = 1'b1;
                iss_idx   = RS_BIT'(i);
            end
        end
    end

    // Operands of the incoming op may be satisfied by a broadcast in the same cycle.
    always_comb begin
        dj_rdy = disp_rj;
        dj_val = disp_vj;
        dk_rdy = disp_rk;
        dk_val = disp_vk;
        if (!disp_rj) begin
            if (cdb_alu_en && disp_qj == cdb_alu_rd) begin
                dj_rdy = 1'b1;
                dj_val = cdb_alu_data;
            end else if (cdb_lsb_en && disp_qj == cdb_lsb_rd) begin
                dj_rdy = 1'b1;
                dj_val = cdb_lsb_data;
            end
        end
        if (!disp_rk) begin
            if (cdb_alu_en && disp_qk == cdb_alu_rd) begin
                dk_rdy = 1'b1;
                dk_val = cdb_alu_data;
            end else if (cdb_lsb_en && disp_qk == cdb_lsb_rd) begin
                dk_rdy = 1'b1;
                dk_val = cdb_lsb_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            busy    <= '0;
            alu_en  <= 1'b0;
            alu_tp  <= '0;
            alu_op  <= '0;
            alu_lhs <= '0;
            alu_rhs <= '0;
            alu_rd  <= '0;
        end else if (en) begin
            alu_en <= iss_fire;
            if (iss_fire) begin
                alu_tp  <= ent_tp[iss_idx];
                alu_op  <= ent_op[iss_idx];
                alu_lhs <= ent_vj[iss_idx];
                alu_rhs <= ent_vk[iss_idx];
                alu_rd  <= ent_rd[iss_idx];
            end
            // Wakeup of waiting operands; ALU bus takes precedence on a tag tie.
            for (int i = 0; i < int'(RS_SIZE); i++) begin
                if (busy[i] && !ent_rj[i]) begin
                    if (cdb_alu_en && ent_qj[i] == cdb_alu_rd) begin
                        ent_vj[i] <= cdb_alu_data;
                        ent_rj[i] <= 1'b1;
                    end else if (cdb_lsb_en && ent_qj[i] == cdb_lsb_rd) begin
                        ent_vj[i] <= cdb_lsb_data;
                        ent_rj[i] <= 1'b1;
                    end
                end
                if (busy[i] && !ent_rk[i]) begin
                    if (cdb_alu_en && ent_qk[i] == cdb_alu_rd) begin
                        ent_vk[i] <= cdb_alu_data;
                        ent_rk[i] <= 1'b1;
                    end else if (cdb_lsb_en && ent_qk[i] == cdb_lsb_rd) begin
                        ent_vk[i] <= cdb_lsb_data;
                        ent_rk[i] <= 1'b1;
                    end
                end
            end
            if (iss_fire) begin
                busy[iss_idx] <= 1'b0;
            end
            if (disp_fire) begin
                busy[free_idx]   <= 1'b1;
                ent_tp[free_idx] <= disp_tp;
                ent_op[free_idx] <= disp_op;
                ent_vj[free_idx] <= dj_val;
                ent_qj[free_idx] <= disp_qj;
                ent_rj[free_idx] <= dj_rdy;
                ent_vk[free_idx] <= dk_val;
                ent_qk[free_idx] <= disp_qk;
                ent_rk[free_idx] <= dk_rdy;
                ent_rd[free_idx] <= disp_rd;
            end
        end else begin
            alu_en <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_rs.sv
// Bench for alu_rs: directed scenarios then random traffic, checked through
// an expectation queue filled by a behavioural model and drained by a monitor.
module tb_alu_rs;

    logic        clk = 1'b0;
    logic        rst, en, clr;
    logic        disp_en;
    logic [2:0]  disp_tp;
    logic [5:0]  disp_op;
    logic [31:0] disp_vj, disp_vk;
    logic [4:0]  disp_qj, disp_qk, disp_rd;
    logic        disp_rj, disp_rk;
    logic        full;
    logic        cdb_alu_en, cdb_lsb_en;
    logic [4:0]  cdb_alu_rd, cdb_lsb_rd;
    logic [31:0] cdb_alu_data, cdb_lsb_data;
    logic        alu_rdy;
    logic        alu_en;
    logic [2:0]  alu_tp;
    logic [5:0]  alu_op;
    logic [31:0] alu_lhs, alu_rhs;
    logic [4:0]  alu_rd;

    alu_rs dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr),
        .disp_en(disp_en), .disp_tp(disp_tp), .disp_op(disp_op),
        .disp_vj(disp_vj), .disp_qj(disp_qj), .disp_rj(disp_rj),
        .disp_vk(disp_vk), .disp_qk(disp_qk), .disp_rk(disp_rk),
        .disp_rd(disp_rd), .full(full),
        .cdb_alu_en(cdb_alu_en), .cdb_alu_rd(cdb_alu_rd), .cdb_alu_data(cdb_alu_data),
        .cdb_lsb_en(cdb_lsb_en), .cdb_lsb_rd(cdb_lsb_rd), .cdb_lsb_data(cdb_lsb_data),
        .alu_rdy(alu_rdy), .alu_en(alu_en), .alu_tp(alu_tp), .alu_op(alu_op),
        .alu_lhs(alu_lhs), .alu_rhs(alu_rhs), .alu_rd(alu_rd)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        en;
        logic [2:0]  tp;
        logic [5:0]  op;
        logic [31:0] lhs;
        logic [31:0] rhs;
        logic [4:0]  rd;
    } out_t;

    typedef struct {
        bit          busy;
        bit [2:0]    tp;
        bit [5:0]    op;
        bit [31:0]   vj, vk;
        bit [4:0]    qj, qk, rd;
        bit          rj, rk;
    } slot_t;

    slot_t m[8];
    out_t  hold;
    out_t  expq[$];
    int    total = 0;
    int    bad   = 0;
    bit    seen_rst = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit model_full();
        bit f = 1'b1;
        foreach (m[i]) f &= m[i].busy;
        return f;
    endfunction

    // Resolve a not-ready operand against the buses (ALU bus first).
    task automatic snoop(inout bit r, inout bit [31:0] v, input bit [4:0] q);
        if (!r) begin
            if (cdb_alu_en && q == cdb_alu_rd) begin r = 1'b1; v = cdb_alu_data; end
            else if (cdb_lsb_en && q == cdb_lsb_rd) begin r = 1'b1; v = cdb_lsb_data; end
        end
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        out_t e;
        int   cand = -1;
        int   slot = -1;
        bit   f = model_full();
        if (seen_rst && !rst) chk("full", full, f);
        e = hold;
        e.en = 1'b0;
        if (rst || clr) begin
            foreach (m[i]) m[i].busy = 1'b0;
            hold = '0;
            e = '0;
            if (rst) seen_rst = 1'b1;
        end else if (en) begin
            foreach (m[i]) if (cand < 0 && m[i].busy && m[i].rj && m[i].rk) cand = i;
            foreach (m[i]) if (slot < 0 && !m[i].busy) slot = i;
            if (alu_rdy && cand >= 0) begin
                e = '{1'b1, m[cand].tp, m[cand].op, m[cand].vj, m[cand].vk, m[cand].rd};
                hold = e;
            end
            foreach (m[i]) if (m[i].busy) begin
                snoop(m[i].rj, m[i].vj, m[i].qj);
                snoop(m[i].rk, m[i].vk, m[i].qk);
            end
            if (disp_en && !f && slot >= 0) begin
                m[slot] = '{1'b1, disp_tp, disp_op, disp_vj, disp_vk,
                            disp_qj, disp_qk, disp_rd, disp_rj, disp_rk};
                snoop(m[slot].rj, m[slot].vj, m[slot].qj);
                snoop(m[slot].rk, m[slot].vk, m[slot].qk);
            end
            if (alu_rdy && cand >= 0) m[cand].busy = 1'b0;
        end
        expq.push_back(e);
    endtask

    // Monitor: compare what the DUT presents against the oldest expectation.
    always @(negedge clk) begin
        out_t e;
        if (expq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL underflow: no expectation queued for output alu_en=%0b", alu_en);
        end else begin
            e = expq.pop_front();
            chk("alu_en", {127'd0, alu_en}, {127'd0, e.en});
            chk("payload", {49'd0, alu_tp, alu_op, alu_lhs, alu_rhs, alu_rd},
                {49'd0, e.tp, e.op, e.lhs, e.rhs, e.rd});
        end
    end

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        disp_en = 1'b0; clr = 1'b0;
        cdb_alu_en = 1'b0; cdb_lsb_en = 1'b0;
    endtask

    task automatic disp(input bit [2:0] tp, input bit [5:0] op,
                        input bit [31:0] vj, input bit [4:0] qj, input bit rj,
                        input bit [31:0] vk, input bit [4:0] qk, input bit rk,
                        input bit [4:0] rd);
        disp_en = 1'b1; disp_tp = tp; disp_op = op;
        disp_vj = vj; disp_qj = qj; disp_rj = rj;
        disp_vk = vk; disp_qk = qk; disp_rk = rk; disp_rd = rd;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; clr = 1'b0; alu_rdy = 1'b0;
        disp_en = 1'b0; disp_tp = '0; disp_op = '0; disp_vj = '0; disp_vk = '0;
        disp_qj = '0; disp_qk = '0; disp_rd = '0; disp_rj = 1'b0; disp_rk = 1'b0;
        cdb_alu_en = 1'b0; cdb_alu_rd = '0; cdb_alu_data = '0;
        cdb_lsb_en = 1'b0; cdb_lsb_rd = '0; cdb_lsb_data = '0;
        do_reset();
        chk("reset_full", full, 1'b0);

        // Plain ready-ready op.
        alu_rdy = 1'b1;
        disp(3'd1, 6'd0, 32'd5, 5'd0, 1'b1, 32'd7, 5'd0, 1'b1, 5'd3);
        cycle(); idle(); cycle(); cycle();

        // lhs woken by ALU broadcast.
        disp(3'd2, 6'd4, 32'd0, 5'd4, 1'b0, 32'd11, 5'd0, 1'b1, 5'd6);
        cycle(); idle();
        cdb_alu_en = 1'b1; cdb_alu_rd = 5'd4; cdb_alu_data = 32'h1234;
        cycle(); idle(); cycle(); cycle();

        // rhs satisfied by LSB broadcast in the dispatch cycle.
        disp(3'd3, 6'd9, 32'd1, 5'd0, 1'b1, 32'd0, 5'd9, 1'b0, 5'd7);
        cdb_lsb_en = 1'b1; cdb_lsb_rd = 5'd9; cdb_lsb_data = 32'hFF;
        cycle(); idle(); cycle(); cycle();

        // Fill all entries, overflow attempt, then drain in index order.
        alu_rdy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            disp(3'(i), 6'(i + 1), 32'(100 + i), 5'd0, 1'b1, 32'(200 + i), 5'd0, 1'b1, 5'(i + 10));
            cycle();
        end
        chk("full_after_8", full, 1'b1);
        disp(3'd7, 6'd63, 32'hDEAD, 5'd0, 1'b1, 32'hBEEF, 5'd0, 1'b1, 5'd31);
        cycle();
        chk("full_after_9th", full, 1'b1);
        idle(); alu_rdy = 1'b1;
        for (int i = 0; i < 10; i++) cycle();
        chk("empty_after_drain", full, 1'b0);

        // Flush with concurrent dispatch and broadcast.
        alu_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            disp(3'd1, 6'd2, 32'(i), 5'd0, 1'b1, 32'(i), 5'd0, 1'b1, 5'(i + 1));
            cycle();
        end
        disp(3'd1, 6'd2, 32'd9, 5'd0, 1'b1, 32'd9, 5'd0, 1'b1, 5'd20);
        cdb_alu_en = 1'b1; cdb_alu_rd = 5'd1; cdb_alu_data = 32'h55;
        clr = 1'b1;
        cycle(); idle();
        chk("full_after_clr", full, 1'b0);
        alu_rdy = 1'b1;
        for (int i = 0; i < 4; i++) cycle();

        // Freeze with ready entries and bus traffic.
        alu_rdy = 1'b0;
        disp(3'd4, 6'd1, 32'd1, 5'd0, 1'b1, 32'd2, 5'd0, 1'b1, 5'd1); cycle();
        disp(3'd4, 6'd2, 32'd0, 5'd6, 1'b0, 32'd3, 5'd0, 1'b1, 5'd2); cycle();
        disp(3'd4, 6'd3, 32'd4, 5'd0, 1'b1, 32'd5, 5'd0, 1'b1, 5'd3); cycle();
        idle(); en = 1'b0; alu_rdy = 1'b1;
        cdb_alu_en = 1'b1; cdb_alu_rd = 5'd6; cdb_alu_data = 32'h66;
        for (int i = 0; i < 3; i++) cycle();
        idle(); en = 1'b1;
        for (int i = 0; i < 5; i++) cycle();
        do_reset();

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 499) == 0);
            clr = ($urandom_range(0, 99) == 0);
            en = ($urandom_range(0, 9) != 0);
            alu_rdy = ($urandom_range(0, 9) < 7);
            disp_en = !model_full() && ($urandom_range(0, 1) == 1);
            disp_tp = 3'($urandom); disp_op = 6'($urandom);
            disp_vj = $urandom; disp_vk = $urandom; disp_rd = 5'($urandom);
            disp_qj = 5'($urandom_range(0, 7)); disp_rj = 1'($urandom_range(0, 1));
            disp_qk = 5'($urandom_range(0, 7)); disp_rk = 1'($urandom_range(0, 1));
            cdb_alu_en = 1'($urandom_range(0, 1)); cdb_alu_rd = 5'($urandom_range(0, 7));
            cdb_alu_data = $urandom;
            cdb_lsb_en = 1'($urandom_range(0, 1)); cdb_lsb_rd = 5'($urandom_range(0, 7));
            cdb_lsb_data = $urandom;
            cycle();
        end
        rst = 1'b0; idle(); en = 1'b1; alu_rdy = 1'b1;
        for (int i = 0; i < 10; i++) cycle();

        @(negedge clk);
        #1;
        chk("queue_drained", 128'(expq.size()), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
